// File: rtl/word_memory_bank.sv
// rtl/word_memory_bank.sv - single-port word memory with valid/ready request and response handshakes
// Optional MEM_CLEAR_EN: sweep the array to zero for DEPTH cycles after every reset.
module word_memory_bank #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 1000,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy
);

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_CLEAR} state_t;
    localparam state_t RST_STATE = S_CLEAR;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             in_range;

    assign in_range  = (32'(addr_q) < DEPTH);
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
`ifdef MEM_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                // Out-of-range addresses never touch the array.
                if (in_range) begin
                    err_d = 1'b0;
                    if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef MEM_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    // Reset gates the write so a transaction caught in ACCESS is dropped cleanly.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_word_memory_bank.sv
// tb/tb_word_memory_bank.sv - directed vector bench for word_memory_bank
module tb_word_memory_bank;
    localparam int WIDTH = 40;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    word_memory_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] exp_rdata;
        logic             exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits out the optional clear sweep; a no-op when the block resets straight to IDLE.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < DEPTH + 50) begin
            step();
            n++;
        end
        check(name, 64'(req_ready), 64'd1);
    endtask

    // Called at a negedge with the block idle; checks the 2-cycle latency on the way.
    task automatic run_txn(input string name, input logic we, input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] wdata,
                           output logic [WIDTH-1:0] rdata, output logic err);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        check({name, "_ready"}, 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check({name, "_access_valid"}, 64'(rsp_valid), 64'd0);
        check({name, "_access_busy"}, 64'(busy), 64'd1);
        step();
        check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        step();
        check({name, "_retired"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             er;
        logic [WIDTH-1:0] exp_q[4];
        int               acc_cyc;
        int               last_acc;
        int               n_acc;
        int               n_rsp;
        logic             acc;

        vecs[0]  = '{"wr5",      1'b1, 10'd5,    40'h12_3456_789A, 40'h12_3456_789A, 1'b0};
        vecs[1]  = '{"rd5",      1'b0, 10'd5,    40'h0,            40'h12_3456_789A, 1'b0};
        vecs[2]  = '{"rd1000",   1'b0, 10'd1000, 40'h0,            40'h0,            1'b1};
        vecs[3]  = '{"wr999",    1'b1, 10'd999,  40'hAA_5555_AAAA, 40'hAA_5555_AAAA, 1'b0};
        vecs[4]  = '{"rd999",    1'b0, 10'd999,  40'h0,            40'hAA_5555_AAAA, 1'b0};
        vecs[5]  = '{"wr0",      1'b1, 10'd0,    40'h1,            40'h1,            1'b0};
        vecs[6]  = '{"rd0",      1'b0, 10'd0,    40'h0,            40'h1,            1'b0};
        vecs[7]  = '{"rd1023",   1'b0, 10'd1023, 40'h0,            40'h0,            1'b1};
        vecs[8]  = '{"wr1000",   1'b1, 10'd1000, 40'hDE_ADBE_EF00, 40'h0,            1'b1};
        vecs[9]  = '{"rd999b",   1'b0, 10'd999,  40'h0,            40'hAA_5555_AAAA, 1'b0};
        vecs[10] = '{"wr5ones",  1'b1, 10'd5,    ONES,             ONES,             1'b0};
        vecs[11] = '{"rd5ones",  1'b0, 10'd5,    40'h0,            ONES,             1'b0};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
`ifdef MEM_CLEAR_EN
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd1);
`else
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
`endif
        wait_ready("reset_done");

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
            check({vecs[i].name, "_rdata"}, 64'(rd), 64'(vecs[i].exp_rdata));
            check({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
        end

        // Stalled response: held stable while a competing write request is offered.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_rdata", 64'(rsp_rdata), 64'(ONES));
            check("stall_req_ready", 64'(req_ready), 64'd0);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5; req_wdata = '0;
            step();
        end
        check("stall_still_valid", 64'(rsp_valid), 64'd1);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        check("stall_retired", 64'(rsp_valid), 64'd0);
        check("stall_idle", 64'(req_ready), 64'd1);
        run_txn("stall_rd5", 1'b0, 10'd5, '0, rd, er);
        check("stall_ignored_write", 64'(rd), 64'(ONES));

        // Reset during ACCESS drops the write to addr 7.
        run_txn("pre_wr7", 1'b1, 10'd7, 40'h55, rd, er);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7; req_wdata = 40'hFF;
        step();
        req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_access_no_rsp", 64'(rsp_valid), 64'd0);
        wait_ready("rst_access_ready");
        check("rst_access_idle_no_rsp", 64'(rsp_valid), 64'd0);
        run_txn("rd7", 1'b0, 10'd7, '0, rd, er);
`ifdef MEM_CLEAR_EN
        check("rd7_after_rst", 64'(rd), 64'h0);
`else
        check("rd7_after_rst", 64'(rd), 64'h55);
`endif

        // Reset during RESP discards the pending response.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd7; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("rst_resp_pending", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        check("rst_resp_dropped", 64'(rsp_valid), 64'd0);
        check("rst_resp_rdata", 64'(rsp_rdata), 64'd0);
        wait_ready("rst_resp_ready");

        // Back-to-back with req_valid held high: write/read pairs, read-after-write.
        exp_q[0] = 40'h01_0203_0405; exp_q[1] = 40'h01_0203_0405;
        exp_q[2] = 40'hF0_E0D0_C0B0; exp_q[3] = 40'hF0_E0D0_C0B0;
        n_acc = 0; n_rsp = 0; last_acc = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd10; req_wdata = exp_q[0];
        for (acc_cyc = 0; acc_cyc < 40 && n_rsp < 4; acc_cyc++) begin
            if (rsp_valid) begin
                check("b2b_rdata", 64'(rsp_rdata), 64'(exp_q[n_rsp]));
                n_rsp++;
            end
            acc = req_valid && req_ready;
            step();
            if (acc) begin
                if (n_acc > 0) check("b2b_spacing", 64'(acc_cyc - last_acc), 64'd3);
                last_acc = acc_cyc;
                n_acc++;
                case (n_acc)
                    1: begin req_we = 1'b0; req_addr = 10'd10; end
                    2: begin req_we = 1'b1; req_addr = 10'd11; req_wdata = exp_q[2]; end
                    3: begin req_we = 1'b0; req_addr = 10'd11; end
                    default: req_valid = 1'b0;
                endcase
            end
        end
        check("b2b_responses", 64'(n_rsp), 64'd4);
        req_valid = 1'b0;
        step();

`ifdef MEM_CLEAR_EN
        begin
            int n = 0;
            run_txn("pre_wr0", 1'b1, 10'd0, 40'h11, rd, er);
            run_txn("pre_wr999", 1'b1, 10'd999, 40'h22, rd, er);
            rst = 1'b1;
            step();
            rst = 1'b0;
            while (!req_ready && n < DEPTH + 50) begin
                step();
                n++;
            end
            check("clear_cycles", 64'(n), 64'(DEPTH));
            run_txn("clr_rd0", 1'b0, 10'd0, '0, rd, er);
            check("clr_rd0_data", 64'(rd), 64'h0);
            run_txn("clr_rd999", 1'b0, 10'd999, '0, rd, er);
            check("clr_rd999_data", 64'(rd), 64'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
